// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buf
// Brief    : FIFO-buffered UART transmitter, valid/ready byte input, 8N1 LSB
//            first. Define UART_TX_PARITY_EN to insert an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 8,
    localparam int FIFO_AW   = $clog2(FIFO_DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_cnt
);

    localparam int c_BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int c_BAUD_W       = (c_BAUD_CNT_MAX > 1) ? $clog2(c_BAUD_CNT_MAX) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_BAUD_CNT_MAX - 1);
    localparam logic [FIFO_AW:0]    c_FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t              r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_fifo_cnt;

    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic                w_fifo_nempty;
    logic                w_tx_next;

    assign w_fifo_nempty = (r_fifo_cnt != '0);
    assign w_bit_end     = (r_baud_cnt == c_BAUD_LAST);
    assign w_push        = tx_valid && tx_ready;
    // A byte leaves the FIFO exactly when the FSM commits to a new start bit.
    assign w_pop         = w_fifo_nempty &&
                           ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (FIFO_AW + 1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (FIFO_AW + 1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // The line register trails the state by one clock, so every bit keeps its
    // full BAUD_CNT_MAX width and consecutive frames abut with no gap.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_next;

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fifo_nempty) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= w_fifo_nempty ? S_START : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end
        end
    end

    assign tx_ready = (r_fifo_cnt != c_FIFO_FULL);
    assign tx       = r_tx;
    assign tx_busy  = (r_state != S_IDLE) || w_fifo_nempty;
    assign fifo_cnt = r_fifo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buf
// Brief    : Self-checking bench for uart_tx_buf (52 clocks per bit, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

    localparam int CLK_FREQ   = 500_000;
    localparam int UART_BPS   = 9600;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT        = 52;
    localparam int N_RAND     = 30;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [3:0] fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, d7..d0, start}; bit 0 goes on the line first
        logic       par;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] fill [9];
    logic [7:0] exp_q [$];
    logic [7:0] rb;
    bit         rok;

    uart_tx_buf #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy),
        .fifo_cnt(fifo_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic check_cnt(input string name, input logic [3:0] act, input logic [3:0] exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Called just after the pop edge; checks first and last cycle of every bit.
    task automatic expect_frame(input logic [9:0] frame, input logic par, input bit last,
                                input string tag);
        logic [NBITS-1:0] bits;
`ifdef UART_TX_PARITY_EN
        bits = {frame[9], par, frame[8:0]};
`else
        bits = frame;
`endif
        for (int k = 0; k < NBITS; k++) begin
            tick(1);
            check_bit({tag, "_bit_first"}, tx, bits[k]);
            if (last && (k == NBITS - 1)) begin
                tick(BIT - 2);
                check_bit({tag, "_busy_tail"}, tx_busy, 1'b1);
                tick(1);
            end else begin
                tick(BIT - 1);
            end
            check_bit({tag, "_bit_last"}, tx, bits[k]);
        end
        if (last) begin
            check_bit({tag, "_busy_end"}, tx_busy, 1'b0);
        end
    endtask

    // Reference receiver: mid-bit sampling of one frame from the line.
    task automatic rx_frame(output logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        ok     = 1'b1;
        b      = '0;
        while (tx !== 1'b0) begin
            tick(1);
            waited++;
            if (waited > 4 * NBITS * BIT) begin
                ok = 1'b0;
                return;
            end
        end
        tick(BIT / 2 - 1);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(BIT);
            b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        tick(BIT);
        if (tx !== ^b) ok = 1'b0;
`endif
        tick(BIT);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1) begin
            tick(1);
            guard++;
            if (guard > 2 * NBITS * BIT) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_ready_timeout: tx_ready stuck at %b, expected 1", tx_ready);
                tx_valid = 1'b0;
                return;
            end
        end
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        exp_q.push_back(b);
    endtask

    initial begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[2] = '{8'h0F, 10'b1_00001111_0, 1'b0};
        vecs[3] = '{8'hF0, 10'b1_11110000_0, 1'b0};
        vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[5] = '{8'h03, 10'b1_00000011_0, 1'b0};
        vecs[6] = '{8'h80, 10'b1_10000000_0, 1'b1};
        vecs[7] = '{8'h3C, 10'b1_00111100_0, 1'b0};
        fill    = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A};

        sys_rst  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        check("reset_state", 32'({tx, tx_ready, tx_busy, fifo_cnt}), 32'(7'b1_1_0_0000));
        sys_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            check("idle_state", 32'({tx, tx_ready, tx_busy, fifo_cnt}), 32'(7'b1_1_0_0000));
        end

        // Single frames: start bit two edges after the push edge.
        for (int v = 0; v < 8; v++) begin
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            check_cnt("push_cnt", fifo_cnt, 4'd1);
            check_bit("push_busy", tx_busy, 1'b1);
            check_bit("push_tx_idle", tx, 1'b1);
            tick(1);
            check_cnt("pop_cnt", fifo_cnt, 4'd0);
            check_bit("pop_tx_idle", tx, 1'b1);
            expect_frame(vecs[v].frame, vecs[v].par, 1'b1, "single");
            tick(5);
        end

        // Back-to-back frames with zero idle gap.
        fork
            begin
                for (int i = 1; i < 4; i++) begin
                    tx_data  = vecs[i].data;
                    tx_valid = 1'b1;
                    tick(1);
                end
                tx_valid = 1'b0;
                check_cnt("b2b_cnt", fifo_cnt, 4'd2);
            end
            begin
                tick(2);
                expect_frame(vecs[1].frame, vecs[1].par, 1'b0, "b2b0");
                expect_frame(vecs[2].frame, vecs[2].par, 1'b0, "b2b1");
                expect_frame(vecs[3].frame, vecs[3].par, 1'b1, "b2b2");
            end
        join
        tick(5);

        // Fill past depth: ninth byte only fits because the first was popped.
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    tx_data  = fill[i];
                    tx_valid = 1'b1;
                    tick(1);
                    check_cnt("fill_cnt", fifo_cnt, 4'((i == 0) ? 1 : i));
                    check_bit("fill_ready", tx_ready, (i == 8) ? 1'b0 : 1'b1);
                end
                tx_data = 8'hEE;
                for (int i = 0; i < 3; i++) begin
                    tick(1);
                    check_cnt("full_hold_cnt", fifo_cnt, 4'd8);
                    check_bit("full_hold_ready", tx_ready, 1'b0);
                end
                tx_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame(rb, rok);
                    check_bit("fill_frame_ok", rok, 1'b1);
                    check_byte("fill_byte", rb, fill[i]);
                end
            end
        join
        tick(100);
        check("fill_drained", 32'({tx, tx_ready, tx_busy, fifo_cnt}), 32'(7'b1_1_0_0000));

        // Reset in the middle of a data bit with two bytes queued.
        tick(10);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        tx_data = 8'hAA;
        tick(1);
        tx_data = 8'hBB;
        tick(1);
        tx_valid = 1'b0;
        check_cnt("rst_pre_cnt", fifo_cnt, 4'd2);
        tick(124);
        check_bit("rst_pre_tx", tx, 1'b0);
        #2;
        sys_rst = 1'b1;
        #1;
        check_bit("rst_async_tx", tx, 1'b1);
        check_cnt("rst_async_cnt", fifo_cnt, 4'd0);
        check_bit("rst_async_ready", tx_ready, 1'b1);
        check_bit("rst_async_busy", tx_busy, 1'b0);
        tick(3);
        sys_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick(1);
            check("post_rst_idle", 32'({tx, tx_busy, fifo_cnt}), 32'(6'b1_0_0000));
        end
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        expect_frame(10'b1_10000001_0, 1'b0, 1'b1, "post_rst");
        tick(5);

        // Random bytes and gaps against the reference receiver.
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    int gap;
                    gap = int'($urandom_range(0, (i % 4 == 0) ? 400 : 3));
                    if (gap > 0) tick(gap);
                    push_byte(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    rx_frame(rb, rok);
                    check_bit("rand_frame_ok", rok, 1'b1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rand_byte: decoded 0x%0h, expected nothing pending", rb);
                    end else begin
                        check_byte("rand_byte", rb, exp_q.pop_front());
                    end
                end
            end
        join
        tick(NBITS * BIT);
        check("final_idle", 32'({tx, tx_ready, tx_busy, fifo_cnt}), 32'(7'b1_1_0_0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
